// File: rtl/pattern_gen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator.
// Imported by the generator top and its down-counter.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam int PAT_W_DEF = 4;

    function automatic int idx_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int IDX_W = idx_w(PAT_W_DEF);

endpackage

// File: rtl/pattern_gen_counter.sv
// Loadable down-counter that saturates at zero.
// tc flags the terminal (zero) count.
module pattern_gen_counter
    import pattern_gen_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !tc) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/pattern_generator.sv
// Serialises a latched pattern MSB-first, repeated with optional
// zero-filled gaps, behind a valid/ready start handshake.
module pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IW = idx_w(PAT_W);
    localparam int CW = (IW > GAP_W) ? IW : GAP_W;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_q;
    logic [GAP_W-1:0] gap_q;

    logic             out_n, valid_n, fs_n, done_n;
    logic             accept;

    logic             b_load, b_dec, b_tc;
    logic [CW-1:0]    b_val, b_cnt;
    logic [IW-1:0]    bi, bi_m1;

    logic             r_load, r_dec, r_zero;
    logic [CNT_W-1:0] reps_left;
    logic             last_rep;

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    assign bi       = b_cnt[IW-1:0];
    assign bi_m1    = bi - IW'(1);
    // zero can only be seen if something went wrong; end the burst anyway
    assign last_rep = (reps_left == CNT_W'(1)) || r_zero;

    // one counter serves as bit index in SHIFT and gap count in GAP
    pattern_gen_counter #(.W(CW)) u_bit (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (b_load),
        .load_val (b_val),
        .dec      (b_dec),
        .count    (b_cnt),
        .tc       (b_tc)
    );

    pattern_gen_counter #(.W(CNT_W)) u_rep (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (r_load),
        .load_val (repeat_cnt),
        .dec      (r_dec),
        .count    (reps_left),
        .tc       (r_zero)
    );

    always_comb begin
        state_n = state;
        out_n   = out;
        valid_n = out_valid;
        fs_n    = 1'b0;
        done_n  = 1'b0;
        accept  = 1'b0;
        b_load  = 1'b0;
        b_val   = CW'(PAT_W - 1);
        b_dec   = 1'b0;
        r_load  = 1'b0;
        r_dec   = 1'b0;
        unique case (state)
            IDLE: begin
                out_n   = 1'b0;
                valid_n = 1'b0;
                if (start_valid) begin
                    accept = 1'b1;
                    r_load = 1'b1;
                    b_load = 1'b1;
                    if (repeat_cnt != '0) begin
                        state_n = SHIFT;
                        out_n   = pattern[PAT_W-1];
                        valid_n = 1'b1;
                        fs_n    = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                    out_n   = 1'b0;
                    valid_n = 1'b0;
                end else if (!b_tc) begin
                    b_dec = 1'b1;
                    out_n = pat_q[bi_m1];
                end else if (last_rep) begin
                    state_n = IDLE;
                    out_n   = 1'b0;
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    r_dec  = 1'b1;
                    b_load = 1'b1;
                    if (gap_q != '0) begin
                        state_n = GAP;
                        out_n   = 1'b0;
                        b_val   = CW'(gap_q);
                    end else begin
                        out_n = pat_q[PAT_W-1];
                        fs_n  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                    out_n   = 1'b0;
                    valid_n = 1'b0;
                end else if (b_cnt == CW'(1) || b_tc) begin
                    state_n = SHIFT;
                    out_n   = pat_q[PAT_W-1];
                    fs_n    = 1'b1;
                    b_load  = 1'b1;
                end else begin
                    b_dec = 1'b1;
                    out_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            out         <= out_n;
            out_valid   <= valid_n;
            frame_start <= fs_n;
            done        <= done_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            gap_q <= '0;
        end else if (accept) begin
            pat_q <= pattern;
            gap_q <= gap_len;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// Scoreboard bench: a stream model queues expected bits/done events,
// and a negedge monitor compares them against the generator.
module tb_pattern_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [2:0] gap_len;
    logic       abort;
    logic       out;
    logic       out_valid;
    logic       frame_start;
    logic       busy;
    logic       done;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        bit is_done;
        bit b;
        bit fs;
    } item_t;

    item_t sb[$];

    pattern_generator #(
        .PAT_W (4),
        .CNT_W (4),
        .GAP_W (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap_len     (gap_len),
        .abort       (abort),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Expected stream from the burst rules: pattern MSB-first,
    // gap zeros between repetitions, done marker on normal completion.
    function automatic void build(input logic [3:0] p,
                                  input int rc,
                                  input int g,
                                  output item_t q[$]);
        item_t it;
        q = {};
        for (int r = 0; r < rc; r++) begin
            if (r > 0) begin
                for (int k = 0; k < g; k++) begin
                    it = '{1'b0, 1'b0, 1'b0};
                    q.push_back(it);
                end
            end
            for (int i = 3; i >= 0; i--) begin
                it = '{1'b0, p[i], (i == 3)};
                q.push_back(it);
            end
        end
        it = '{1'b1, 1'b0, 1'b0};
        q.push_back(it);
    endfunction

    // mode: 0 normal, 1 abort in cycle cut, 2 async reset in cycle cut
    task automatic burst(input logic [3:0] p,
                         input int rc,
                         input int g,
                         input int mode,
                         input int cut,
                         input bit ab_start);
        item_t q[$];
        int    len;
        len = (rc == 0) ? 0 : rc * 4 + (rc - 1) * g;
        build(p, rc, g, q);
        if (mode == 0) begin
            foreach (q[i]) sb.push_back(q[i]);
        end else if (mode == 1) begin
            for (int i = 0; i < cut; i++) sb.push_back(q[i]);
        end else begin
            for (int i = 0; i < cut - 1; i++) sb.push_back(q[i]);
        end
        chk("ready_before_start", start_ready, 1);
        start_valid = 1'b1;
        pattern     = p;
        repeat_cnt  = 4'(rc);
        gap_len     = 3'(g);
        abort       = ab_start;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        abort       = 1'b0;
        pattern     = 4'($urandom);
        repeat_cnt  = 4'($urandom);
        gap_len     = 3'($urandom);
        if (mode == 0) begin
            repeat (len) begin
                @(posedge clk);
                #1;
            end
        end else if (mode == 1) begin
            repeat (cut - 1) begin
                @(posedge clk);
                #1;
            end
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk("abort_ready", start_ready, 1);
            chk("abort_valid", out_valid, 0);
            chk("abort_done", done, 0);
        end else begin
            repeat (cut - 1) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_out", out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_fs", frame_start, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    // Monitor: pops one expected item per stream bit or done pulse.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy_eq_valid", busy, out_valid);
                chk("ready_eq_idle", start_ready, !busy);
                if (!out_valid) begin
                    chk("idle_out", out, 0);
                    chk("idle_fs", frame_start, 0);
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        it = sb.pop_front();
                        chk("bit_not_done", it.is_done, 0);
                        chk("bit", out, it.b);
                        chk("frame_start", frame_start, it.fs);
                    end
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        it = sb.pop_front();
                        chk("done_marker", it.is_done, 1);
                    end
                end
            end
        end
    end

    initial begin
        int rc, g, mode, cut, len, idle;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        pattern     = '0;
        repeat_cnt  = '0;
        gap_len     = '0;
        abort       = 1'b0;
        #2;
        chk("reset_out", out, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_fs", frame_start, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("ready_after_reset", start_ready, 1);

        burst(4'b1011, 2, 2, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        burst(4'b1111, 0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        burst(4'b1101, 3, 0, 0, 0, 1'b0);
        burst(4'b0110, 1, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        burst(4'b1001, 4, 1, 1, 3, 1'b0);
        @(posedge clk);
        #1;
        burst(4'b1011, 2, 2, 2, 5, 1'b0);
        burst(4'b1011, 2, 2, 0, 0, 1'b0);
        burst(4'b0101, 1, 3, 0, 0, 1'b1);
        burst(4'b1110, 2, 7, 0, 0, 1'b0);
        burst(4'b0011, 15, 7, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rc   = $urandom_range(0, 6);
            g    = $urandom_range(0, 7);
            len  = (rc == 0) ? 0 : rc * 4 + (rc - 1) * g;
            mode = 0;
            cut  = 0;
            if (len > 1 && $urandom_range(0, 5) == 0) begin
                mode = 1;
                cut  = $urandom_range(1, len);
            end else if (len > 2 && $urandom_range(0, 9) == 0) begin
                mode = 2;
                cut  = $urandom_range(2, len);
            end
            burst(4'($urandom), rc, g, mode, cut,
                  1'($urandom_range(0, 3) == 0));
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
